// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter and framer for two message sources
// sharing one byte-wide UART transmitter. Each granted message goes out as
// HDR0 HDR1 LEN payload[0..LEN-1] CHK, where CHK is the XOR of LEN and payload.
module uart_tx_sched #(
  parameter logic [7:0] HDR0        = 8'hAA,
  parameter logic [7:0] HDR1        = 8'h55,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] len0,
  input  logic [7:0] len1,
  input  logic [7:0] rd_data0,
  input  logic [7:0] rd_data1,
  output logic [7:0] rd_addr,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       err,
  output logic       uart_en,
  output logic [7:0] uart_din,
  input  logic       uart_tx_busy
);

  localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_IDLE, SEND, WAIT_DONE, NEXT
  } state_t;

  state_t           state, state_nxt;
  logic             src, src_nxt;      // granted source: 0 -> req0, 1 -> req1
  logic             ptr, ptr_nxt;      // 1 -> favour req1 on contention
  logic [7:0]       len_r, len_nxt;
  logic [8:0]       idx, idx_nxt;      // 9 bits: len=255 runs idx up to 258
  logic [8:0]       idx_inc, last_idx;
  logic [7:0]       chk, chk_nxt;
  logic [7:0]       sel_byte;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       rd_addr_nxt, uart_din_nxt;
  logic             uart_en_nxt, gnt0_nxt, gnt1_nxt;
  logic             done0_nxt, done1_nxt, err_nxt;
  logic             pick, in_chk, is_last;

  assign last_idx = {1'b0, len_r} + 9'd3;
  assign idx_inc  = idx + 9'd1;
  assign is_last  = (idx == last_idx);
  assign in_chk   = (idx >= 9'd2) && (idx < last_idx);
  assign pick     = (req0 && req1) ? ptr : req1;

  // Byte selected for the current frame position
  always_comb begin
    if (idx == 9'd0)      sel_byte = HDR0;
    else if (idx == 9'd1) sel_byte = HDR1;
    else if (idx == 9'd2) sel_byte = len_r;
    else if (is_last)     sel_byte = chk;
    else if (src)         sel_byte = rd_data1;
    else                  sel_byte = rd_data0;
  end

  // Next-state and next-output logic for the arbiter/framer FSM
  always_comb begin
    state_nxt    = state;
    src_nxt      = src;
    ptr_nxt      = ptr;
    len_nxt      = len_r;
    idx_nxt      = idx;
    chk_nxt      = chk;
    cnt_nxt      = cnt;
    rd_addr_nxt  = rd_addr;
    uart_en_nxt  = uart_en;
    uart_din_nxt = uart_din;
    gnt0_nxt     = gnt0;
    gnt1_nxt     = gnt1;
    done0_nxt    = 1'b0;
    done1_nxt    = 1'b0;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          src_nxt     = pick;
          len_nxt     = pick ? len1 : len0;
          idx_nxt     = 9'd0;
          chk_nxt     = 8'd0;
          rd_addr_nxt = 8'd0;
          gnt0_nxt    = ~pick;
          gnt1_nxt    = pick;
          state_nxt   = LOAD;
        end
      end
      // rd_addr was presented in the previous cycle, so rd_data is valid here
      LOAD: begin
        uart_din_nxt = sel_byte;
        if (in_chk) chk_nxt = chk ^ sel_byte;
        state_nxt = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (!uart_tx_busy) begin
          uart_en_nxt = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = SEND;
        end
      end
      SEND: begin
        if (uart_tx_busy) begin
          uart_en_nxt = 1'b0;
          state_nxt   = WAIT_DONE;
        end else if (cnt == CNT_LAST) begin
          uart_en_nxt = 1'b0;
          gnt0_nxt    = 1'b0;
          gnt1_nxt    = 1'b0;
          err_nxt     = 1'b1;
          ptr_nxt     = ~src;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      // done and gnt are registered here so they appear right after busy falls;
      // the next payload address is issued now so it is valid through NEXT
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          state_nxt = NEXT;
          if (is_last) begin
            gnt0_nxt  = 1'b0;
            gnt1_nxt  = 1'b0;
            done0_nxt = ~src;
            done1_nxt = src;
            ptr_nxt   = ~src;
          end else if ((idx_inc >= 9'd3) && (idx_inc < last_idx)) begin
            rd_addr_nxt = idx_inc[7:0] - 8'd3;
          end
        end
      end
      NEXT: begin
        if (is_last) begin
          state_nxt = IDLE;
        end else begin
          idx_nxt   = idx_inc;
          state_nxt = LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame without a pulse
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      src      <= 1'b0;
      ptr      <= 1'b0;
      len_r    <= 8'd0;
      idx      <= 9'd0;
      chk      <= 8'd0;
      cnt      <= '0;
      rd_addr  <= 8'd0;
      uart_en  <= 1'b0;
      uart_din <= 8'd0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      src      <= src_nxt;
      ptr      <= ptr_nxt;
      len_r    <= len_nxt;
      idx      <= idx_nxt;
      chk      <= chk_nxt;
      cnt      <= cnt_nxt;
      rd_addr  <= rd_addr_nxt;
      uart_en  <= uart_en_nxt;
      uart_din <= uart_din_nxt;
      gnt0     <= gnt0_nxt;
      gnt1     <= gnt1_nxt;
      done0    <= done0_nxt;
      done1    <= done1_nxt;
      err      <= err_nxt;
    end
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Two-requester round-robin scheduler and framer that sits in front of the `uart_send` byte transmitter. It grants the UART to one message source at a time. It reads the granted source's payload through a synchronous read port. It wraps the payload as `AA 55 LEN payload CHK` and sequences each byte into the transmitter with a level-`uart_en` / `uart_tx_busy` handshake.

## Interface
- `HDR0`, default 8'hAA, first header byte
- `HDR1`, default 8'h55, second header byte
- `ACK_TIMEOUT`, default 16, cycles allowed from `uart_en` high to `uart_tx_busy` high
- `sys_clk`  in  1  clock
- `sys_rst_n`  in  1  asynchronous, active-low reset
- `req0`, `req1`  in  1  level request; hold high until matching `done`/`err`
- `len0`, `len1`  in  8  payload length, 0..255; sampled at grant
- `rd_data0`, `rd_data1`  in  8  source read data, valid one cycle after `rd_addr`
- `rd_addr`  out  8  payload byte index, shared by both sources
- `gnt0`, `gnt1`  out  1  high for the whole frame of the granted source (one-hot or zero)
- `done0`, `done1`  out  1  one-cycle pulse: frame completed
- `err`  out  1  one-cycle pulse: handshake timeout, frame aborted
- `uart_en`  out  1  to transmitter; held high until busy is seen
- `uart_din`  out  8  to transmitter; stable whenever `uart_en` is high
- `uart_tx_busy`  in  1  from transmitter

## Operation
- States: IDLE, LOAD, WAIT_IDLE, SEND, WAIT_DONE, NEXT.
- **IDLE**
  - With no request, stay in IDLE.
  - With only one request, grant it.
  - With both requesting, grant the source not served last. After reset the pointer favours `req0`.
  - On grant: latch `len`, set `idx`=0, clear `chk`, assert `gnt`, go to LOAD.
- **Byte index `idx`** (9-bit, 0..len+3) selects the byte:
  - 0 → `HDR0`
  - 1 → `HDR1`
  - 2 → `len`
  - 3..len+2 → `rd_data` of the granted source, at `rd_addr`=idx-3
  - len+3 → `chk`
- **LOAD**
  - Drive `rd_addr`.
  - One cycle later, register the selected byte into `uart_din`.
  - XOR the byte into `chk` when idx is 2..len+2. `chk` is the XOR of LEN and all payload bytes; headers are excluded.
  - Go to WAIT_IDLE.
- **WAIT_IDLE**: wait until `uart_tx_busy`=0, then assert `uart_en` and go to SEND.
- **SEND**
  - Hold `uart_en`=1 and count cycles.
  - On `uart_tx_busy`=1: drop `uart_en`, go to WAIT_DONE.
  - If the count reaches `ACK_TIMEOUT` first: drop `uart_en` and `gnt`, pulse `err`, update the pointer, go to IDLE.
- **WAIT_DONE**: wait for `uart_tx_busy`=0, then go to NEXT.
- **NEXT**
  - If idx = len+3: drop `gnt`, pulse `done`, update the pointer, go to IDLE.
  - Otherwise: increment idx, go to LOAD.
- Requests deasserted mid-frame are ignored; the frame completes.
- A new grant needs at least one IDLE cycle after `done`/`err`.

## Timing
- Reset values: `uart_en`=0, `uart_din`=0, `rd_addr`=0, `gnt0`/`gnt1`=0, `done0`/`done1`=0, `err`=0. FSM goes to IDLE, pointer favours `req0`.
- Reset mid-frame aborts immediately. No `done`/`err` pulse is generated.
- Grant latency: `gnt` is high in the cycle after `req` is seen in IDLE.
- `uart_en` rises no earlier than 2 cycles after `gnt`. The transmitter raises busy 2–3 cycles after `uart_en`.
- `uart_din` changes only in LOAD, never while `uart_en`=1 or busy=1.
- Inter-byte overhead: 3 cycles (NEXT, LOAD, WAIT_IDLE) plus the transmitter's edge-detect latency after busy falls.
- Frame length: len+4 bytes. len=0 gives `HDR0 HDR1 00 00`. len=255 needs idx up to 258, hence the 9-bit index.
- `done` is asserted in the cycle after the busy fall of the checksum byte. `gnt` falls in that same cycle.

## Test plan
- **Single frame:** `req0`, len0=3, data 11,22,33 → line bytes AA 55 03 11 22 33 03; one `done0` pulse; `gnt1` never high.
- **Empty payload:** `req1`, len1=0 → bytes AA 55 00 00; `rd_addr` never advances; `done1` pulses once.
- **Contention:** both requests held high with len=1 → order req0, req1, req0; `gnt0` and `gnt1` are never high together; at least one IDLE cycle between frames.
- **Timeout:** transmitter model keeps busy at 0 → `uart_en` high for 16 cycles, then `err` pulses; `gnt0` falls; next grant goes to `req1` if it is pending.
- **Reset mid-frame:** assert `sys_rst_n`=0 during payload byte 2 → all outputs at reset values asynchronously; after release with `req0` high, the frame restarts from AA.
- **Handshake integrity:** busy delayed 3 cycles after `uart_en` → `uart_din` stable through busy rise; exactly one byte sent per `uart_en` high period.
